// File: rtl/rv_ctrl_fsm.sv
// Multicycle control sequencer for the RV32I core: drives datapath strobes and keeps cycle/instret counters.
// Optional feature: define RV_CTRL_ILLEGAL_TRAP_EN to halt in TRAP on illegal instructions (default: NOP).
module rv_ctrl_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        store,
    input  logic        branch,
    input  logic        jalr,
    input  logic        jal,
    input  logic        lui,
    input  logic        auipc,
    input  logic        op_imm,
    input  logic        op,
    input  logic        system,
    input  logic        br_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_data,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        halt,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
`else
        ST_WRITEBACK = 3'd5
`endif
    } state_t;

    state_t      state_r;
    logic [31:0] cycle_cnt_r;
    logic [31:0] instret_cnt_r;

    logic        illegal_s;
    logic        mem_req_s;
    logic        mem_we_s;
    logic        mem_is_data_s;
    logic        ir_we_s;
    logic        pc_we_s;
    logic        pc_sel_s;
    logic        alu_a_sel_s;
    logic        alu_b_sel_s;
    logic        reg_we_s;
    logic [1:0]  wb_sel_s;
    logic        retire_s;
    logic        halt_s;

    assign illegal_s = system | ~(load | store | branch | jalr | jal | lui | auipc | op_imm | op);

    // State sequencing; a low rst_n abandons any pending memory handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RESET;
        end else begin
            case (state_r)
                ST_RESET:     state_r <= ST_FETCH;
                ST_FETCH:     state_r <= mem_ack ? ST_DECODE : ST_FETCH;
                ST_DECODE:    state_r <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (branch) begin
                        state_r <= ST_FETCH;
                    end else if (load | store) begin
                        state_r <= ST_MEM;
                    end else if (illegal_s) begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                        state_r <= ST_TRAP;
`else
                        state_r <= ST_FETCH;
`endif
                    end else begin
                        state_r <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        state_r <= store ? ST_FETCH : ST_WRITEBACK;
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_WRITEBACK: state_r <= ST_FETCH;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                ST_TRAP:      state_r <= ST_TRAP;
`endif
                default:      state_r <= ST_RESET;
            endcase
        end
    end

    // Cycle and retired-instruction counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_r   <= 32'd0;
            instret_cnt_r <= 32'd0;
        end else begin
            if (state_r != ST_RESET) begin
                cycle_cnt_r <= cycle_cnt_r + 32'd1;
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            if (retire_s) begin
                instret_cnt_r <= instret_cnt_r + 32'd1;
            end else begin
                instret_cnt_r <= instret_cnt_r;
            end
        end
    end

    // Datapath strobes decoded from state and class flags; all quiet while rst_n is low.
    always_comb begin
        mem_req_s     = 1'b0;
        mem_we_s      = 1'b0;
        mem_is_data_s = 1'b0;
        ir_we_s       = 1'b0;
        pc_we_s       = 1'b0;
        pc_sel_s      = 1'b0;
        alu_a_sel_s   = 1'b0;
        alu_b_sel_s   = 1'b0;
        reg_we_s      = 1'b0;
        wb_sel_s      = 2'd0;
        retire_s      = 1'b0;
        halt_s        = 1'b0;
        if (!rst_n) begin
            mem_req_s = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    mem_req_s = 1'b1;
                    ir_we_s   = mem_ack;
                end
                ST_EXECUTE: begin
                    alu_a_sel_s = auipc | jal | branch;
                    alu_b_sel_s = ~op;
                    if (branch) begin
                        pc_we_s  = 1'b1;
                        pc_sel_s = br_taken;
                        retire_s = 1'b1;
                    end else if (load | store) begin
                        pc_we_s = 1'b0;
                    end else if (illegal_s) begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                        pc_we_s = 1'b0;
`else
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
`endif
                    end else begin
                        pc_we_s = 1'b0;
                    end
                end
                ST_MEM: begin
                    mem_req_s     = 1'b1;
                    mem_is_data_s = 1'b1;
                    mem_we_s      = store;
                    if (mem_ack && store) begin
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                    end else begin
                        pc_we_s = 1'b0;
                    end
                end
                ST_WRITEBACK: begin
                    reg_we_s = 1'b1;
                    pc_we_s  = 1'b1;
                    retire_s = 1'b1;
                    if (load) begin
                        wb_sel_s = 2'd1;
                    end else if (jal | jalr) begin
                        wb_sel_s = 2'd2;
                        pc_sel_s = 1'b1;
                    end else if (lui) begin
                        wb_sel_s = 2'd3;
                    end else begin
                        wb_sel_s = 2'd0;
                    end
                end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    halt_s = 1'b1;
                end
`endif
                default: begin
                    mem_req_s = 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_s;
    assign mem_we      = mem_we_s;
    assign mem_is_data = mem_is_data_s;
    assign ir_we       = ir_we_s;
    assign pc_we       = pc_we_s;
    assign pc_sel      = pc_sel_s;
    assign alu_a_sel   = alu_a_sel_s;
    assign alu_b_sel   = alu_b_sel_s;
    assign reg_we      = reg_we_s;
    assign wb_sel      = wb_sel_s;
    assign retire      = retire_s;
    assign halt        = halt_s;
    assign cycle_cnt   = cycle_cnt_r;
    assign instret_cnt = instret_cnt_r;

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Scoreboard bench for rv_ctrl_fsm: randomized instruction classes and memory waits against a per-instruction model.
module tb_rv_ctrl_fsm;

    localparam int C_LOAD = 0, C_STORE = 1, C_BRANCH = 2, C_JALR = 3, C_JAL = 4;
    localparam int C_LUI = 5, C_AUIPC = 6, C_OPIMM = 7, C_OP = 8, C_SYS = 9, C_NONE = 10;

    typedef struct {
        int          lat;
        logic        pc_sel;
        logic [1:0]  wb_sel;
        logic        reg_we;
        int          exec_idx;
        logic        alu_a;
        logic        alu_b;
        logic [31:0] instret;
        logic [31:0] cyc;
    } exp_t;

    typedef struct {
        int   wait_n;
        logic is_data;
        logic we;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  flags_v;
    logic        br_taken;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_is_data, ir_we, pc_we, pc_sel;
    logic        alu_a_sel, alu_b_sel, reg_we, retire, halt;
    logic [1:0]  wb_sel;
    logic [31:0] cycle_cnt, instret_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    req_t req_q[$];
    bit   resp_en = 1'b0;
    bit   mon_en = 1'b0;
    bit   fetch_ack_now = 1'b0;
    int   sum_lat = 0;
    int   n_ret = 0;

    rv_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n),
        .load(flags_v[0]), .store(flags_v[1]), .branch(flags_v[2]), .jalr(flags_v[3]),
        .jal(flags_v[4]), .lui(flags_v[5]), .auipc(flags_v[6]), .op_imm(flags_v[7]),
        .op(flags_v[8]), .system(flags_v[9]),
        .br_taken(br_taken), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_data(mem_is_data), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire), .halt(halt),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Build the expectation of one instruction from the class rules and start it.
    task automatic push_instr(input int cls, input logic br, input int fw, input int mw);
        exp_t e;
        req_t r;
        bit   ldst;
        bit   illegal;
        ldst    = (cls == C_LOAD) || (cls == C_STORE);
        illegal = (cls == C_SYS) || (cls == C_NONE);
        if (cls == C_BRANCH || illegal) e.lat = 3;
        else if (cls == C_LOAD)         e.lat = 5;
        else                            e.lat = 4;
        e.lat     = e.lat + fw + (ldst ? mw : 0);
        e.pc_sel  = (cls == C_BRANCH) ? br : ((cls == C_JAL || cls == C_JALR) ? 1'b1 : 1'b0);
        e.reg_we  = !(cls == C_BRANCH || cls == C_STORE || illegal);
        e.wb_sel  = (cls == C_LOAD) ? 2'd1 : (cls == C_JAL || cls == C_JALR) ? 2'd2 :
                    (cls == C_LUI) ? 2'd3 : 2'd0;
        e.exec_idx = fw + 3;
        e.alu_a   = (cls == C_AUIPC || cls == C_JAL || cls == C_BRANCH);
        e.alu_b   = (cls != C_OP);
        e.instret = n_ret;
        e.cyc     = sum_lat + e.lat - 1;
        sum_lat   = sum_lat + e.lat;
        n_ret     = n_ret + 1;
        exp_q.push_back(e);
        r.wait_n = fw; r.is_data = 1'b0; r.we = 1'b0;
        req_q.push_back(r);
        if (ldst) begin
            r.wait_n = mw; r.is_data = 1'b1; r.we = (cls == C_STORE);
            req_q.push_back(r);
        end
        flags_v  = (cls <= C_SYS) ? (10'd1 << cls) : 10'd0;
        br_taken = br;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) return;
        end
        errors++;
        $display("FAIL retire_timeout actual=none required=retire");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Memory responder: acks each request after its scheduled wait; random acks while idle.
    initial begin
        req_t cur;
        bit   active = 1'b0;
        int   wcnt = 0;
        forever begin
            @(posedge clk); #2;
            if (!resp_en) begin
                active = 1'b0;
                fetch_ack_now = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    if (req_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_mem_req actual=1 required=0 at %0t", $time);
                    end else begin
                        cur = req_q.pop_front();
                        active = 1'b1;
                        wcnt = 0;
                    end
                end
                if (active) begin
                    chk("mem_is_data", mem_is_data, cur.is_data);
                    chk("mem_we", mem_we, cur.we);
                    if (wcnt == cur.wait_n) begin
                        mem_ack = 1'b1;
                        active = 1'b0;
                        fetch_ack_now = !cur.is_data;
                    end else begin
                        mem_ack = 1'b0;
                        fetch_ack_now = 1'b0;
                        wcnt++;
                    end
                end else begin
                    mem_ack = 1'b0;
                    fetch_ack_now = 1'b0;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                fetch_ack_now = 1'b0;
            end
        end
    end

    // Monitor: per-cycle strobe checks and scoreboard pop on every retire.
    initial begin
        exp_t e;
        bit   started = 1'b0;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                started = 1'b0;
                cyc = 0;
            end else begin
                if (!started && mem_req) started = 1'b1;
                if (started) begin
                    cyc++;
                    chk("ir_we", ir_we, fetch_ack_now);
                    if (exp_q.size() > 0 && cyc == exp_q[0].exec_idx) begin
                        chk("alu_a_sel", alu_a_sel, exp_q[0].alu_a);
                        chk("alu_b_sel", alu_b_sel, exp_q[0].alu_b);
                    end
                    if (retire) begin
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL spurious_retire actual=1 required=0 at %0t", $time);
                        end else begin
                            e = exp_q.pop_front();
                            chk("latency", cyc, e.lat);
                            chk("pc_we", pc_we, 1'b1);
                            chk("pc_sel", pc_sel, e.pc_sel);
                            chk("reg_we", reg_we, e.reg_we);
                            if (e.reg_we) chk("wb_sel", wb_sel, e.wb_sel);
                            chk("instret_cnt", instret_cnt, e.instret);
                            chk("cycle_cnt", cycle_cnt, e.cyc);
                        end
                        cyc = 0;
                    end else begin
                        chk("idle_strobes", {pc_we, reg_we}, 2'b00);
                    end
                end
            end
        end
    end

    initial begin
        int cls_max;
        int fw;
        rst_n = 1'b0; mem_ack = 1'b0; flags_v = 10'd0; br_taken = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_strobes", {mem_req, mem_we, mem_is_data, ir_we, pc_we, pc_sel, alu_a_sel,
                                  alu_b_sel, reg_we, wb_sel, retire, halt}, 13'd0);
            chk("reset_cnt", cycle_cnt | instret_cnt, 32'd0);
        end
        push_instr(C_OP, 1'b0, 0, 0);
        resp_en = 1'b1; mon_en = 1'b1; rst_n = 1'b1;
        #1;
        chk("reset_state_req", mem_req, 1'b0);
        chk("reset_state_cnt", cycle_cnt, 32'd0);
        @(negedge clk); #1;
        chk("first_fetch_req", mem_req, 1'b1);
        chk("first_fetch_cycle", cycle_cnt, 32'd0);
        chk("first_fetch_instret", instret_cnt, 32'd0);
        wait_done();
        push_instr(C_LOAD, 1'b0, 0, 3);   wait_done();
        push_instr(C_BRANCH, 1'b1, 0, 0); wait_done();
        push_instr(C_BRANCH, 1'b0, 1, 0); wait_done();
        push_instr(C_STORE, 1'b0, 2, 1);  wait_done();
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        cls_max = C_OP;
`else
        cls_max = C_NONE;
        push_instr(C_NONE, 1'b0, 0, 0); wait_done();
`endif
        for (int i = 0; i < 150; i++) begin
            push_instr($urandom_range(0, cls_max), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            wait_done();
        end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        fw = $urandom_range(0, 2);
        begin
            req_t r;
            r.wait_n = fw; r.is_data = 1'b0; r.we = 1'b0;
            req_q.push_back(r);
        end
        flags_v = 10'd0;
        repeat (fw + 6) @(negedge clk);
        chk("trap_halt", halt, 1'b1);
        chk("trap_req", mem_req, 1'b0);
        chk("trap_cycle", cycle_cnt, sum_lat + fw + 5);
        repeat (5) @(negedge clk);
        chk("trap_halt_hold", halt, 1'b1);
        chk("trap_instret_frozen", instret_cnt, n_ret);
        chk("trap_cycle_runs", cycle_cnt, sum_lat + fw + 10);
`endif
        resp_en = 1'b0; mon_en = 1'b0; mem_ack = 1'b0; flags_v = 10'd1 << C_OP;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_fetch_req", mem_req, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; mem_ack = 1'b1;
        #1;
        chk("rst_mid_ir_we", ir_we, 1'b0);
        chk("rst_mid_req", mem_req, 1'b0);
        @(negedge clk);
        chk("rst_mid_cnt", cycle_cnt | instret_cnt, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("late_ack_ignored", {mem_req, ir_we, pc_we, retire}, 4'd0);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch", mem_req, 1'b1);
        chk("post_rst_cycle", cycle_cnt, 32'd0);
        chk("post_rst_instret", instret_cnt, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
